// File: rtl/mem_stage_dm.sv
// mem_stage_dm: memory stage with a direct-mapped, write-through, no-write-allocate data cache
// and a req/ack backing-memory port; loads pulse MRSModify on completion.
module mem_stage_dm #(
    parameter int DATA_W   = 32,
    parameter int TAG_ID_W = 4,
    parameter int REG_W    = 5,
    parameter int LINES    = 16,
    parameter int IDX_W    = $clog2(LINES)
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic                req_store,
    input  logic [DATA_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [TAG_ID_W-1:0] RT,
    input  logic [REG_W-1:0]    RWriteReg,
    input  logic                RRegWrite,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   ReadData,
    output logic [TAG_ID_W-1:0] RTo,
    output logic [REG_W-1:0]    RWriteRego,
    output logic                RRegWriteo,
    output logic                MRSModify,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t state, nextState;
    logic [LINES-1:0] lineValid;
    logic [TAG_W-1:0] lineTag [LINES];
    logic [DATA_W-1:0] lineData [LINES];
    logic [DATA_W-3:0] capWord;
    logic [DATA_W-1:0] capData;
    logic [TAG_ID_W-1:0] capRT;
    logic [REG_W-1:0] capReg;
    logic capRegWrite;
    logic accept, hit, busyAck;
    logic [IDX_W-1:0] reqIdx, capIdx;
    logic [TAG_W-1:0] reqTag, capTag;

    assign reqIdx    = Addr[IDX_W+1:2];
    assign reqTag    = Addr[DATA_W-1:IDX_W+2];
    assign capIdx    = capWord[IDX_W-1:0];
    assign capTag    = capWord[DATA_W-3:IDX_W];
    assign hit       = lineValid[reqIdx] && lineTag[reqIdx] == reqTag;
    assign req_ready = state == IDLE;
    assign accept    = req_valid && state == IDLE;
    // mem_ack outside a pending access is ignored
    assign busyAck   = mem_ack && state != IDLE;
    assign mem_req   = state != IDLE;
    assign mem_we    = state == WR_THRU;
    assign mem_addr  = {capWord, 2'b00};
    assign mem_wdata = capData;

    always_comb begin
        nextState = state;
        nextState = accept ? (req_store ? WR_THRU : (req_load && !hit ? RD_MISS : IDLE))
                  : (busyAck ? IDLE : state);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            lineValid   <= '0;
            capWord     <= '0;
            capData     <= '0;
            capRT       <= '0;
            capReg      <= '0;
            capRegWrite <= 1'b0;
            resp_valid  <= 1'b0;
            MRSModify   <= 1'b0;
            ReadData    <= '0;
            RTo         <= '0;
            RWriteRego  <= '0;
            RRegWriteo  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            MRSModify  <= 1'b0;
            if (accept) begin
                capWord     <= Addr[DATA_W-1:2];
                capData     <= WriteData;
                capRT       <= RT;
                capReg      <= RWriteReg;
                capRegWrite <= RRegWrite;
                if (!req_store && (!req_load || hit)) begin
                    resp_valid <= 1'b1;
                    MRSModify  <= req_load;
                    ReadData   <= req_load ? lineData[reqIdx] : Addr;
                    RTo        <= RT;
                    RWriteRego <= RWriteReg;
                    RRegWriteo <= RRegWrite;
                end
            end else if (busyAck) begin
                resp_valid <= 1'b1;
                MRSModify  <= state == RD_MISS;
                ReadData   <= state == RD_MISS ? mem_rdata : '0;
                RTo        <= capRT;
                RWriteRego <= capReg;
                RRegWriteo <= capRegWrite && state == RD_MISS;
                if (state == RD_MISS) lineValid[capIdx] <= 1'b1;
            end
        end
    end

    // tag/data arrays need no reset: a line is meaningless until its valid bit is set
    always_ff @(posedge CLK) begin
        if (accept && req_store && hit) lineData[reqIdx] <= WriteData;
        else if (busyAck && state == RD_MISS) begin
            lineData[capIdx] <= mem_rdata;
            lineTag[capIdx]  <= capTag;
        end
    end
endmodule

// File: tb/tb_mem_stage_dm.sv
// tb_mem_stage_dm: directed table, corner sequences and random traffic for mem_stage_dm,
// checked against a word-level memory model plus a per-index residency model.
module tb_mem_stage_dm;
    localparam int LINES = 16;
    localparam logic [1:0] K_NOP = 2'd0, K_LD = 2'd1, K_ST = 2'd2, K_BOTH = 2'd3;

    logic CLK = 1'b0, reset;
    logic req_valid, req_ready, req_load, req_store, RRegWrite;
    logic [31:0] Addr, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata;
    logic [3:0] RT, RTo;
    logic [4:0] RWriteReg, RWriteRego;
    logic resp_valid, RRegWriteo, MRSModify, mem_req, mem_we, mem_ack;

    mem_stage_dm #(.DATA_W(32), .TAG_ID_W(4), .REG_W(5), .LINES(LINES)) dut (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .Addr(Addr), .WriteData(WriteData),
        .RT(RT), .RWriteReg(RWriteReg), .RRegWrite(RRegWrite), .resp_valid(resp_valid),
        .ReadData(ReadData), .RTo(RTo), .RWriteRego(RWriteRego), .RRegWriteo(RRegWriteo),
        .MRSModify(MRSModify), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rt;
        logic [4:0]  rg;
        logic        rw;
        logic        expMem;
        logic [31:0] expData;
        logic        expMrs;
        logic        expRw;
    } vec_t;

    int checks = 0, errors = 0;
    int ackDelay = 2;
    bit spurious = 0;
    int waitCnt = 0;
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] backMem [logic [31:0]];
    bit resValid [LINES];
    logic [31:0] resAddr [LINES];

    function automatic logic [31:0] initVal(logic [31:0] a);
        return a == 32'h40 ? 32'hDEADBEEF : a ^ 32'hA5A50000;
    endfunction

    function automatic logic [31:0] refRd(logic [31:0] wa);
        return refMem.exists(wa) ? refMem[wa] : initVal(wa);
    endfunction

    // backing memory: acks after ackDelay cycles of mem_req, applies write-through data
    always begin
        @(posedge CLK);
        #2;
        if (mem_ack) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else if (mem_req) begin
            if (waitCnt >= ackDelay) begin
                mem_ack = 1'b1;
                if (mem_we) backMem[mem_addr] = mem_wdata;
                else mem_rdata = backMem.exists(mem_addr) ? backMem[mem_addr] : initVal(mem_addr);
            end else waitCnt++;
        end else begin
            waitCnt = 0;
            if (spurious) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hFFFFFFFF;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t predict(logic [1:0] k, logic [31:0] a, logic [31:0] wd,
                                     logic [3:0] rt, logic [4:0] rg, logic rw);
        vec_t v;
        logic [31:0] wa;
        int idx;
        wa = a & ~32'd3;
        idx = int'((wa >> 2) % LINES);
        v.kind = k; v.addr = a; v.wdata = wd; v.rt = rt; v.rg = rg; v.rw = rw;
        if (k[1]) begin
            v.expMem = 1'b1; v.expData = 32'd0; v.expMrs = 1'b0; v.expRw = 1'b0;
        end else if (k[0]) begin
            v.expMem = !(resValid[idx] && resAddr[idx] == wa);
            v.expData = refRd(wa); v.expMrs = 1'b1; v.expRw = rw;
        end else begin
            v.expMem = 1'b0; v.expData = a; v.expMrs = 1'b0; v.expRw = rw;
        end
        return v;
    endfunction

    task automatic modelUpdate(vec_t v);
        logic [31:0] wa;
        int idx;
        wa = v.addr & ~32'd3;
        idx = int'((wa >> 2) % LINES);
        if (v.kind[1]) refMem[wa] = v.wdata;
        else if (v.kind[0]) begin
            resValid[idx] = 1'b1;
            resAddr[idx] = wa;
        end
    endtask

    task automatic doReq(vec_t v);
        int n, lat;
        bit sawMem, done;
        n = 0;
        while (!req_ready && n < 40) begin tick(); n++; end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_load = v.kind[0]; req_store = v.kind[1];
        Addr = v.addr; WriteData = v.wdata; RT = v.rt; RWriteReg = v.rg; RRegWrite = v.rw;
        tick();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        sawMem = 0; done = 0; lat = 0;
        while (!done && lat < 40) begin
            if (resp_valid) done = 1;
            else begin
                if (mem_req && !sawMem) begin
                    chk("mem_we", 32'(mem_we), 32'(v.kind[1]));
                    chk("mem_addr", mem_addr, v.addr & ~32'd3);
                    if (v.kind[1]) chk("mem_wdata", mem_wdata, v.wdata);
                end
                sawMem |= mem_req;
                tick();
                lat++;
            end
        end
        chk("resp_seen", 32'(done), 32'd1);
        chk("mem_access", 32'(sawMem), 32'(v.expMem));
        chk("latency", 32'(lat), v.expMem ? 32'(ackDelay + 1) : 32'd0);
        chk("ReadData", ReadData, v.expData);
        chk("RTo", 32'(RTo), 32'(v.rt));
        chk("RWriteRego", 32'(RWriteRego), 32'(v.rg));
        chk("RRegWriteo", 32'(RRegWriteo), 32'(v.expRw));
        chk("MRSModify", 32'(MRSModify), 32'(v.expMrs));
        tick();
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        modelUpdate(v);
    endtask

    vec_t tbl [14];
    logic [31:0] bbA [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{K_LD,   32'h40, 32'h0,        4'd3,  5'd2,  1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[1]  = '{K_LD,   32'h40, 32'h0,        4'd4,  5'd2,  1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
        tbl[2]  = '{K_ST,   32'h40, 32'h12345678, 4'd5,  5'd3,  1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{K_LD,   32'h40, 32'h0,        4'd6,  5'd4,  1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1};
        tbl[4]  = '{K_LD,   32'h80, 32'h0,        4'd7,  5'd5,  1'b1, 1'b1, 32'hA5A50080, 1'b1, 1'b1};
        tbl[5]  = '{K_LD,   32'h40, 32'h0,        4'd8,  5'd6,  1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0};
        tbl[6]  = '{K_NOP,  32'h55, 32'h0,        4'd9,  5'd7,  1'b1, 1'b0, 32'h55,       1'b0, 1'b1};
        tbl[7]  = '{K_LD,   32'h44, 32'h0,        4'd1,  5'd8,  1'b1, 1'b1, 32'hA5A50044, 1'b1, 1'b1};
        tbl[8]  = '{K_LD,   32'h48, 32'h0,        4'd2,  5'd9,  1'b1, 1'b1, 32'hA5A50048, 1'b1, 1'b1};
        tbl[9]  = '{K_ST,   32'h84, 32'hCAFEF00D, 4'd10, 5'd10, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{K_LD,   32'h44, 32'h0,        4'd11, 5'd11, 1'b1, 1'b0, 32'hA5A50044, 1'b1, 1'b1};
        tbl[11] = '{K_LD,   32'h84, 32'h0,        4'd12, 5'd12, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1};
        tbl[12] = '{K_BOTH, 32'h48, 32'h0BADF00D, 4'd13, 5'd13, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0};
        tbl[13] = '{K_LD,   32'h4A, 32'h0,        4'd14, 5'd14, 1'b1, 1'b0, 32'h0BADF00D, 1'b1, 1'b1};
        bbA = '{32'h40, 32'h44, 32'h48};
        reset = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        Addr = '0; WriteData = '0; RT = '0; RWriteReg = '0; RRegWrite = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        #2 reset = 1'b1;
        tick(); tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ReadData", ReadData, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) doReq(tbl[i]);

        // back-to-back hits after making 0x44 resident again
        doReq(predict(K_LD, 32'h44, 32'h0, 4'd0, 5'd1, 1'b1));
        req_valid = 1'b1; req_load = 1'b1; RRegWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Addr = bbA[i]; RT = 4'(i + 1);
            tick();
            chk("b2b_ready", 32'(req_ready), 32'd1);
            chk("b2b_no_mem", 32'(mem_req), 32'd0);
            chk("b2b_resp", 32'(resp_valid), 32'd1);
            chk("b2b_data", ReadData, refRd(bbA[i]));
            chk("b2b_RTo", 32'(RTo), 32'(i + 1));
        end
        req_valid = 1'b0; req_load = 1'b0;
        tick();
        chk("b2b_end", 32'(resp_valid), 32'd0);

        // mem_ack while idle must be ignored
        spurious = 1;
        tick();
        spurious = 0;
        tick();
        chk("idle_ack_resp", 32'(resp_valid), 32'd0);
        chk("idle_ack_ready", 32'(req_ready), 32'd1);
        doReq(predict(K_LD, 32'h40, 32'h0, 4'd5, 5'd5, 1'b1));

        // minimum miss latency: ack in the first mem_req cycle
        ackDelay = 0;
        doReq(predict(K_LD, 32'h300, 32'h0, 4'd6, 5'd6, 1'b1));

        // reset in the middle of a miss
        ackDelay = 6;
        req_valid = 1'b1; req_load = 1'b1; Addr = 32'h200; RT = 4'd9;
        tick();
        req_valid = 1'b0; req_load = 1'b0;
        tick();
        chk("miss_pending", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_RTo", 32'(RTo), 32'd0);
        chk("rst_mid_ReadData", ReadData, 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        tick();
        reset = 1'b0;
        foreach (resValid[i]) resValid[i] = 1'b0;
        ackDelay = 2;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abandoned_no_resp", 32'(resp_valid), 32'd0);
        end
        doReq(predict(K_LD, 32'h40, 32'h0, 4'd7, 5'd7, 1'b1));

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            ackDelay = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = a | 32'h0010_0000;
            doReq(predict(2'($urandom_range(0, 3)), a, $urandom, 4'($urandom), 5'($urandom),
                          1'($urandom)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
